mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Parametrised multicycle control FSM for the RV32I datapath; next generation of the control unit.
//  Adds memory ready/req handshake with watchdog, illegal-opcode and bus-timeout traps, halt/resume,
//  and optional multicycle MUL/DIV sequencing. Drives datapath mux/enable signals from state + opcode;
//  ALUOp feeds alucontrol.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles waiting for mem_ready before bus-timeout trap (>=1)
//  EN_MULDIV     1   1: ART with funct7=7'b0000001 enters MULDIV state; 0: treated as illegal
//  MULDIV_CYCLES 32  cycles spent in MULDIV (>=1)
//  EN_TRAP       1   1: illegal opcode -> TRAP; 0: illegal opcode -> FETCH (skip)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  instruction  in   32  current IR contents
//  mem_ready    in   1   memory completes the pending mem_req this cycle
//  resume       in   1   leave HALT (single-cycle pulse)
//  mem_req      out  1   memory access request (fetch or data)
//  PCWriteCond, PCWrite, RegWrite, MemRead, MemWrite, IRWrite, MemtoReg, IorD, ALUSrcA  out 1 datapath ctrl
//  ALUSrcB      out  2   00 reg B, 01 const 4, 10 imm, 11 imm (branch offset)
//  PCSource     out  2   00 ALU, 01 ALUOut (branch), 10 JAL target, 11 JALR target
//  ALUOp        out  2   00 add, 01 branch cmp, 10 funct-decoded, 11 pass imm (LUI)
//  trap         out  1   one-cycle pulse on entering TRAP
//  trap_cause   out  2   00 none, 01 illegal opcode, 10 bus timeout, 11 ECALL/EBREAK; held until resume
//  halted       out  1   high while in HALT
//  state        out  4   current state encoding (debug)
// BEHAVIOUR
//  States: RST_IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MULDIV=4 MEM_ACCESS=5 WRITE_BACK=6 BRANCH=7 TRAP=8 HALT=9.
//  Reset: state=RST_IDLE, wait counter=0, muldiv counter=0, trap_cause=00; all outputs 0. RST_IDLE->FETCH next clk.
//  Outputs are decoded from state (+opcode): every control output defaults 0 each cycle; no latched values.
//  Opcodes: LUI 0110111 AUIPC 0010111 JAL 1101111 JALR 1100111 BRANCH 1100011 LOAD 0000011
//           STORE 0100011 IMM 0010011 ART 0110011 SYSTEM 1110011; any other = illegal.
//  FETCH: mem_req=MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. If mem_ready: IRWrite=PCWrite=1,
//    PCSource=00 -> DECODE. Else wait counter++; counter==MEM_WAIT_MAX -> TRAP cause 10.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. BRANCH->BRANCH; LOAD/STORE/LUI/AUIPC/JAL/JALR/IMM/ART->EXECUTE
//    (ART funct7=0000001 with EN_MULDIV->MULDIV, counter=0); SYSTEM->TRAP cause 11; illegal->TRAP cause 01
//    (EN_TRAP=1) or FETCH (EN_TRAP=0).
//  EXECUTE: LUI ALUSrcB=10 ALUOp=11; AUIPC ALUSrcA=0 ALUSrcB=10 ALUOp=00; IMM ALUSrcA=1 ALUSrcB=10 ALUOp=10;
//    ART ALUSrcA=1 ALUSrcB=00 ALUOp=10 -> WRITE_BACK. LOAD/STORE ALUSrcA=1 ALUSrcB=10 ALUOp=00 -> MEM_ACCESS.
//    JAL/JALR: PCWrite=RegWrite=1, PCSource=10/11 -> FETCH.
//  MULDIV: ALUSrcA=1 ALUSrcB=00 ALUOp=10; counter++; at counter==MULDIV_CYCLES-1 -> WRITE_BACK.
//  MEM_ACCESS: mem_req=1, IorD=1, MemRead(LOAD)/MemWrite(STORE) held until mem_ready. On mem_ready:
//    LOAD->WRITE_BACK, STORE->FETCH. Same watchdog as FETCH -> TRAP cause 10.
//  WRITE_BACK: RegWrite=1; MemtoReg=1 for LOAD, else 0 -> FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01 -> FETCH.
//  TRAP: trap=1 one cycle; trap_cause registered on entry -> HALT.
//  HALT: halted=1, all datapath outputs 0; resume -> FETCH, trap_cause cleared; else stay.
//  Wait counter: cleared on every state change and on mem_ready; saturates, never wraps.
//  mem_ready outside FETCH/MEM_ACCESS ignored. resume outside HALT ignored.
//  rst_n low at any time (incl. mid-access/MULDIV): immediate return to reset values, request dropped.
// TESTING
//  1. rst_n low then high, ADDI (0x00500093), mem_ready=1 always -> RST_IDLE,FETCH,DECODE,EXECUTE,WRITE_BACK,FETCH; RegWrite only in WB.
//  2. LW with mem_ready delayed 3 cycles in MEM_ACCESS -> mem_req/IorD/MemRead held 4 cycles, then WB MemtoReg=1.
//  3. mem_ready never asserted in FETCH, MEM_WAIT_MAX=15 -> trap pulse after 15 wait cycles, trap_cause=10, halted=1.
//  4. instruction opcode 7'b1111111 -> TRAP cause 01 then HALT; resume pulse -> FETCH, trap_cause=00.
//  5. MUL (funct7=0000001, ART) MULDIV_CYCLES=32 -> exactly 32 cycles in MULDIV, then WB RegWrite=1.
//  6. rst_n asserted in 2nd MULDIV cycle -> outputs 0 and state=0 asynchronously; BEQ -> BRANCH PCWriteCond=1 PCSource=01.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: fetch/decode/execute sequencing with memory handshake,
// bus watchdog, trap/halt handling and optional multicycle MUL/DIV.
module mc_control_fsm #(
    parameter int MEM_WAIT_MAX  = 15,
    parameter int EN_MULDIV     = 1,
    parameter int MULDIV_CYCLES = 32,
    parameter int EN_TRAP       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        resume,
    output logic        mem_req,
    output logic        PCWriteCond,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        IorD,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic        halted,
    output logic [3:0]  state
);

    localparam int WW = $clog2(MEM_WAIT_MAX + 1);
    localparam int MW = $clog2(MULDIV_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_WAIT_MAX);
    localparam logic [MW-1:0] MD_LAST  = MW'(MULDIV_CYCLES - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_ART    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_RST_IDLE   = 4'd0,
        S_FETCH      = 4'd1,
        S_DECODE     = 4'd2,
        S_EXECUTE    = 4'd3,
        S_MULDIV     = 4'd4,
        S_MEM_ACCESS = 4'd5,
        S_WRITE_BACK = 4'd6,
        S_BRANCH     = 4'd7,
        S_TRAP       = 4'd8,
        S_HALT       = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d, wait_sat;
    logic [MW-1:0]   md_q, md_d;
    logic [1:0]      cause_q, cause_d;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic            is_load, is_muldiv, wd_expire;
    logic            unused_bits;

    assign opcode      = instruction[6:0];
    assign funct7      = instruction[31:25];
    assign unused_bits = ^instruction[24:7];
    assign is_load     = (opcode == OP_LOAD);
    assign is_muldiv   = (opcode == OP_ART) && (funct7 == 7'b0000001);
    // Saturating increment: a long stall can never wrap the watchdog back to zero.
    assign wait_sat    = (wait_q == WAIT_MAX) ? wait_q : wait_q + WW'(1);
    assign wd_expire   = (wait_sat == WAIT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST_IDLE;
            wait_q  <= '0;
            md_q    <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            md_q    <= md_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        md_d        = '0;
        cause_d     = cause_q;
        mem_req     = 1'b0;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        trap        = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_RST_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_sat;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM:
                        state_d = S_EXECUTE;
                    OP_ART: begin
                        if (!is_muldiv)          state_d = S_EXECUTE;
                        else if (EN_MULDIV != 0) state_d = S_MULDIV;
                        else if (EN_TRAP != 0) begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end else                 state_d = S_FETCH;
                    end
                    OP_SYSTEM: begin
                        state_d = S_TRAP;
                        cause_d = 2'b11;
                    end
                    default: begin
                        if (EN_TRAP != 0) begin
                            state_d = S_TRAP;
                            cause_d = 2'b01;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_EXECUTE: begin
                state_d = S_WRITE_BACK;
                case (opcode)
                    OP_LUI: begin
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b11;
                    end
                    OP_AUIPC: ALUSrcB = 2'b10;
                    OP_IMM: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b10;
                    end
                    OP_ART: begin
                        ALUSrcA = 1'b1;
                        ALUOp   = 2'b10;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUSrcA = 1'b1;
                        ALUSrcB = 2'b10;
                        state_d = S_MEM_ACCESS;
                    end
                    OP_JAL, OP_JALR: begin
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                        PCSource = (opcode == OP_JAL) ? 2'b10 : 2'b11;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MULDIV: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                if (md_q == MD_LAST) state_d = S_WRITE_BACK;
                else                 md_d    = md_q + MW'(1);
            end
            S_MEM_ACCESS: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = is_load;
                MemWrite = !is_load;
                if (mem_ready) begin
                    state_d = is_load ? S_WRITE_BACK : S_FETCH;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_sat;
                end
            end
            S_WRITE_BACK: begin
                RegWrite = 1'b1;
                MemtoReg = is_load;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                state_d = S_HALT;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = S_FETCH;
                    cause_d = 2'b00;
                end
            end
            default: state_d = S_RST_IDLE;
        endcase
    end

    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with default parameters (15 / 1 / 32 / 1).
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        resume;
    logic        mem_req, PCWriteCond, PCWrite, RegWrite, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, IorD, ALUSrcA, trap, halted;
    logic [1:0]  ALUSrcB, PCSource, ALUOp, trap_cause;
    logic [3:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
        .resume(resume), .mem_req(mem_req), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .trap(trap), .trap_cause(trap_cause),
        .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_addi();
        logic [3:0] exp_st [4] = '{4'd2, 4'd3, 4'd6, 4'd1};
        logic       exp_rw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0; mem_ready = 1'b1; resume = 1'b0; instruction = 32'h0050_0093;
        #3;
        n_tests++;
        if (state !== 4'd0 || mem_req !== 1'b0 || RegWrite !== 1'b0 || trap_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_vals state=%0d mem_req=%b rw=%b cause=%b want 0/0/0/00",
                     state, mem_req, RegWrite, trap_cause);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (state !== 4'd1 || mem_req !== 1'b1 || MemRead !== 1'b1 || IRWrite !== 1'b1 ||
            PCWrite !== 1'b1 || ALUSrcB !== 2'b01 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ctrl state=%0d req=%b rd=%b ir=%b pcw=%b srcb=%b rw=%b want 1/1/1/1/1/01/0",
                     state, mem_req, MemRead, IRWrite, PCWrite, ALUSrcB, RegWrite);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (state !== exp_st[i] || RegWrite !== exp_rw[i]) begin
                n_fail++;
                $display("FAIL addi_seq[%0d] state=%0d rw=%b want %0d/%b",
                         i, state, RegWrite, exp_st[i], exp_rw[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        instruction = 32'h0000_2083;
        tick(); tick();
        n_tests++;
        if (state !== 4'd3 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUOp !== 2'b00) begin
            n_fail++;
            $display("FAIL lw_exec state=%0d a=%b b=%b op=%b want 3/1/10/00", state, ALUSrcA, ALUSrcB, ALUOp);
        end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            n_tests++;
            if (state !== 4'd5 || mem_req !== 1'b1 || IorD !== 1'b1 || MemRead !== 1'b1 || MemWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL lw_mem[%0d] state=%0d req=%b iord=%b rd=%b wr=%b want 5/1/1/1/0",
                         i, state, mem_req, IorD, MemRead, MemWrite);
            end
            tick();
        end
        n_tests++;
        if (state !== 4'd6 || RegWrite !== 1'b1 || MemtoReg !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_wb state=%0d rw=%b m2r=%b want 6/1/1", state, RegWrite, MemtoReg);
        end
        tick();
    endtask

    task automatic test_fetch_timeout();
        int cnt = 0;
        mem_ready = 1'b0;
        while (state == 4'd1 && cnt < 40) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt !== 15 || state !== 4'd8 || trap !== 1'b1 || trap_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_timeout waits=%0d state=%0d trap=%b cause=%b want 15/8/1/10",
                     cnt, state, trap, trap_cause);
        end
        tick();
        mem_ready = 1'b1;
        tick();
        n_tests++;
        if (state !== 4'd9 || halted !== 1'b1 || trap !== 1'b0 || mem_req !== 1'b0 || trap_cause !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_hold state=%0d halted=%b trap=%b req=%b cause=%b want 9/1/0/0/10",
                     state, halted, trap, mem_req, trap_cause);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_tests++;
        if (state !== 4'd1 || halted !== 1'b0 || trap_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL resume state=%0d halted=%b cause=%b want 1/0/00", state, halted, trap_cause);
        end
    endtask

    task automatic test_trap_decode(input logic [31:0] instr, input logic [1:0] cause, input string nm);
        instruction = instr;
        tick(); tick();
        n_tests++;
        if (state !== 4'd8 || trap !== 1'b1 || trap_cause !== cause) begin
            n_fail++;
            $display("FAIL %s_trap state=%0d trap=%b cause=%b want 8/1/%b", nm, state, trap, trap_cause, cause);
        end
        tick();
        n_tests++;
        if (state !== 4'd9 || halted !== 1'b1 || trap_cause !== cause) begin
            n_fail++;
            $display("FAIL %s_halt state=%0d halted=%b cause=%b want 9/1/%b", nm, state, halted, trap_cause, cause);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_tests++;
        if (state !== 4'd1 || trap_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_resume state=%0d cause=%b want 1/00", nm, state, trap_cause);
        end
    endtask

    task automatic test_jal();
        instruction = 32'h0000_006F;
        tick(); tick();
        n_tests++;
        if (state !== 4'd3 || PCWrite !== 1'b1 || RegWrite !== 1'b1 || PCSource !== 2'b10) begin
            n_fail++;
            $display("FAIL jal_exec state=%0d pcw=%b rw=%b pcsrc=%b want 3/1/1/10", state, PCWrite, RegWrite, PCSource);
        end
        tick();
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL jal_next state=%0d want 1", state);
        end
    endtask

    task automatic test_muldiv();
        int cnt = 0;
        instruction = 32'h0231_00B3;
        tick(); tick();
        n_tests++;
        if (state !== 4'd4 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00 || ALUOp !== 2'b10 || RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL muldiv_ctrl state=%0d a=%b b=%b op=%b rw=%b want 4/1/00/10/0",
                     state, ALUSrcA, ALUSrcB, ALUOp, RegWrite);
        end
        while (state == 4'd4 && cnt < 100) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt !== 32 || state !== 4'd6 || RegWrite !== 1'b1 || MemtoReg !== 1'b0) begin
            n_fail++;
            $display("FAIL muldiv_len cycles=%0d state=%0d rw=%b m2r=%b want 32/6/1/0", cnt, state, RegWrite, MemtoReg);
        end
        tick();
    endtask

    task automatic test_reset_mid_muldiv_then_beq();
        instruction = 32'h0231_00B3;
        tick(); tick(); tick();
        n_tests++;
        if (state !== 4'd4) begin
            n_fail++;
            $display("FAIL muldiv_2nd state=%0d want 4", state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd0 || ALUOp !== 2'b00 || ALUSrcA !== 1'b0 || RegWrite !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset state=%0d op=%b a=%b rw=%b req=%b want 0/00/0/0/0",
                     state, ALUOp, ALUSrcA, RegWrite, mem_req);
        end
        instruction = 32'h0000_0063;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (state !== 4'd7 || PCWriteCond !== 1'b1 || PCSource !== 2'b01 || ALUOp !== 2'b01 ||
            ALUSrcA !== 1'b1 || PCWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL beq state=%0d pwc=%b pcsrc=%b op=%b a=%b pcw=%b want 7/1/01/01/1/0",
                     state, PCWriteCond, PCSource, ALUOp, ALUSrcA, PCWrite);
        end
        tick();
        n_tests++;
        if (state !== 4'd1) begin
            n_fail++;
            $display("FAIL beq_next state=%0d want 1", state);
        end
    endtask

    initial begin
        test_reset_addi();
        test_load_wait();
        test_fetch_timeout();
        mem_ready = 1'b1;
        test_trap_decode(32'h0000_007F, 2'b01, "illegal");
        test_trap_decode(32'h0000_0073, 2'b11, "ecall");
        test_jal();
        test_muldiv();
        test_reset_mid_muldiv_then_beq();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish, got t=%0t want < 200000", $time);
        $fatal(1);
    end

endmodule
